// File: rtl/pulse_gate_sequencer.sv
// Gates a pulse counter over a whole number of 50 Hz sync periods, snapshots the
// count at the end of each window and hands the snapshot to two readers (LCD, UART).
module pulse_gate_sequencer #(
    parameter int CNT_W = 32,
    parameter int WID_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [7:0]       win_len,
    input  logic             sync_50Hz,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [CNT_W-1:0] snap,
    output logic             snap_valid,
    input  logic [1:0]       rd_req,
    output logic [1:0]       rd_gnt,
    output logic [WID_W-1:0] win_id,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_LATCH,
        S_CLEAR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sync;
    logic               r_cont;
    logic [7:0]         r_win_len;
    logic [7:0]         r_period;
    logic               r_cnt_en;
    logic [1:0]         r_pend;
    logic [1:0]         r_gnt;
    logic               r_rr_ptr;
    logic [CNT_W-1:0]   r_snap;
    logic [WID_W-1:0]   r_win_id;
    logic               r_overrun;

    logic               w_edge;
    logic               w_term;
    logic               w_accept;
    logic               w_latch;
    logic               w_period_clr;
    logic               w_period_inc;
    logic               w_cnt_clr;
    logic [1:0]         w_elig;
    logic [1:0]         w_gnt;

    assign w_edge = sync_50Hz & ~r_sync;
    assign w_term = (r_period == (r_win_len - 8'd1));

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_latch      = 1'b0;
        w_period_clr = 1'b0;
        w_period_inc = 1'b0;
        w_cnt_clr    = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_edge) begin
                        w_cnt_clr    = 1'b1;
                        w_period_clr = 1'b1;
                        w_state_nxt  = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_edge) begin
                        if (w_term) begin
                            w_state_nxt = S_LATCH;
                        end else begin
                            w_period_inc = 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    w_cnt_clr = 1'b1;
                    if (r_cont) begin
                        w_period_clr = 1'b1;
                        w_state_nxt  = S_COUNT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Round-robin arbiter: only readers with an unread snapshot are eligible.
    always_comb begin
        w_elig = rd_req & r_pend;
        w_gnt  = 2'b00;
        case (w_elig)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync    <= 1'b0;
            r_cont    <= 1'b0;
            r_win_len <= '0;
            r_period  <= '0;
            r_cnt_en  <= 1'b0;
            r_pend    <= 2'b00;
            r_gnt     <= 2'b00;
            r_rr_ptr  <= 1'b0;
            r_snap    <= '0;
            r_win_id  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= sync_50Hz;
            // Enable follows COUNT one cycle late, which yields the 3-cycle dead time.
            r_cnt_en <= (r_state == S_COUNT) && (w_state_nxt == S_COUNT);
            if (w_accept) begin
                r_win_len <= (win_len == 8'd0) ? 8'd1 : win_len;
                r_cont    <= cont;
            end
            if (w_period_clr) begin
                r_period <= '0;
            end else if (w_period_inc) begin
                r_period <= r_period + 8'd1;
            end
            r_gnt <= w_gnt;
            if (w_gnt != 2'b00) begin
                r_rr_ptr <= w_gnt[0];
            end
            // A new snapshot re-arms both readers even if a grant lands this cycle.
            r_pend <= (r_pend & ~w_gnt) | {2{w_latch}};
            if (w_latch) begin
                r_snap <= cnt_in;
            end
            if (w_accept) begin
                r_win_id <= '0;
            end else if (w_latch) begin
                r_win_id <= r_win_id + 1'b1;
            end
            if (w_accept) begin
                r_overrun <= 1'b0;
            end else if (w_latch && (r_pend != 2'b00)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign cnt_en     = r_cnt_en;
    assign cnt_clr    = w_cnt_clr;
    assign snap       = r_snap;
    assign snap_valid = |r_pend;
    assign rd_gnt     = r_gnt;
    assign win_id     = r_win_id;
    assign busy       = (r_state != S_IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pulse_gate_sequencer.sv
// Directed bench for pulse_gate_sequencer: single-shot, continuous, readers,
// overrun, stop handling, win_id wrap and asynchronous reset.
module tb_pulse_gate_sequencer;

    localparam int CNT_W = 32;
    localparam int WID_W = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             cont;
    logic [7:0]       win_len;
    logic             sync_50Hz;
    logic [CNT_W-1:0] cnt_in;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] snap;
    logic             snap_valid;
    logic [1:0]       rd_req;
    logic [1:0]       rd_gnt;
    logic [WID_W-1:0] win_id;
    logic             busy;
    logic             overrun;

    int n_cmp;
    int n_err;
    logic [WID_W-1:0] exp_wid;

    pulse_gate_sequencer #(.CNT_W(CNT_W), .WID_W(WID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .win_len   (win_len),
        .sync_50Hz (sync_50Hz),
        .cnt_in    (cnt_in),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .snap      (snap),
        .snap_valid(snap_valid),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .win_id    (win_id),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_edge();
        sync_50Hz = 1'b1;
        cyc();
        sync_50Hz = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    busy,       0);
        chk({tag, "_cnt_en"},  cnt_en,     0);
        chk({tag, "_cnt_clr"}, cnt_clr,    0);
        chk({tag, "_snap"},    snap,       0);
        chk({tag, "_svalid"},  snap_valid, 0);
        chk({tag, "_rd_gnt"},  rd_gnt,     0);
        chk({tag, "_win_id"},  win_id,     0);
        chk({tag, "_overrun"}, overrun,    0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cont      = 1'b0;
        win_len   = 8'd0;
        sync_50Hz = 1'b0;
        cnt_in    = '0;
        rd_req    = 2'b00;
        #1;
        chk_all_zero("reset");
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Single-shot window of 3 periods
        start = 1'b1; win_len = 8'd3; cont = 1'b0;
        cyc();
        start = 1'b0;
        chk("ss_busy_arm", busy, 1);
        chk("ss_en_arm", cnt_en, 0);
        sync_50Hz = 1'b1;
        #1;
        chk("ss_clr_edge1", cnt_clr, 1);
        cyc();
        sync_50Hz = 1'b0;
        chk("ss_clr_after", cnt_clr, 0);
        cyc();
        chk("ss_en_count", cnt_en, 1);
        sync_edge(); cyc();
        sync_edge(); cyc();
        chk("ss_en_p3", cnt_en, 1);
        cnt_in = 32'd1234;
        sync_edge();
        chk("ss_en_latch", cnt_en, 0);
        chk("ss_busy_latch", busy, 1);
        cyc();
        chk("ss_snap", snap, 1234);
        chk("ss_svalid", snap_valid, 1);
        chk("ss_win_id", win_id, 1);
        chk("ss_clr_clear", cnt_clr, 1);
        cyc();
        chk("ss_idle", busy, 0);
        chk("ss_en_idle", cnt_en, 0);

        // Both readers at once
        rd_req = 2'b11;
        cyc();
        chk("rd_gnt_lcd", rd_gnt, 2'b01);
        chk("rd_sv_mid", snap_valid, 1);
        cyc();
        chk("rd_gnt_uart", rd_gnt, 2'b10);
        chk("rd_sv_done", snap_valid, 0);
        cyc();
        chk("rd_gnt_held", rd_gnt, 2'b00);
        rd_req = 2'b00;

        // Continuous, win_len=0 behaves as 1
        start = 1'b1; cont = 1'b1; win_len = 8'd0;
        cyc();
        start = 1'b0;
        sync_edge(); cyc(); cyc();
        chk("ct_en_on", cnt_en, 1);
        cnt_in = 32'd100;
        sync_edge();
        chk("ct_gap1", cnt_en, 0);
        cyc();
        chk("ct_gap2", cnt_en, 0);
        chk("ct_snap1", snap, 100);
        chk("ct_wid1", win_id, 1);
        chk("ct_ovr0", overrun, 0);
        cyc();
        chk("ct_gap3", cnt_en, 0);
        cyc();
        chk("ct_en_back", cnt_en, 1);
        rd_req = 2'b01;
        cyc();
        chk("ct_gnt_lcd", rd_gnt, 2'b01);
        rd_req = 2'b00;
        cyc();
        cnt_in = 32'd200;
        sync_edge(); cyc();
        chk("ov_set", overrun, 1);
        chk("ov_snap", snap, 200);
        chk("ov_wid2", win_id, 2);
        cyc(); cyc();

        // stop in COUNT, then start+stop in IDLE
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_en", cnt_en, 0);
        chk("stop_wid", win_id, 2);
        chk("stop_gnt", rd_gnt, 0);
        chk("stop_snap", snap, 200);
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_stop_busy", busy, 0);
        chk("ss_stop_ovr", overrun, 1);

        // start clears overrun; an edge coincident with start is ignored
        start = 1'b1; cont = 1'b0; win_len = 8'd2; sync_50Hz = 1'b1;
        cyc();
        start = 1'b0; sync_50Hz = 1'b0;
        chk("st_ovr_clr", overrun, 0);
        chk("st_wid_clr", win_id, 0);
        chk("st_busy", busy, 1);
        chk("st_noclr", cnt_clr, 0);
        cyc();
        chk("st_still_arm", cnt_clr, 0);
        chk("st_en_arm", cnt_en, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // Round-robin: LCD was granted last, so UART goes first
        rd_req = 2'b11;
        cyc();
        chk("rr_first_uart", rd_gnt, 2'b10);
        cyc();
        chk("rr_then_lcd", rd_gnt, 2'b01);
        rd_req = 2'b00;
        cyc();

        // Grant coinciding with LATCH, then win_id wrap
        start = 1'b1; cont = 1'b1; win_len = 8'd0;
        cyc();
        start = 1'b0;
        exp_wid = '0;
        sync_edge(); cyc(); cyc();
        cnt_in = 32'd1;
        sync_edge(); cyc();
        exp_wid = exp_wid + 1'b1;
        chk("wr_wid_1", win_id, exp_wid);
        cyc(); cyc();
        rd_req = 2'b10;
        cyc();
        chk("lg_uart", rd_gnt, 2'b10);
        rd_req = 2'b00;
        cyc();
        cnt_in = 32'd2;
        sync_edge();
        rd_req = 2'b01;
        cyc();
        rd_req = 2'b00;
        exp_wid = exp_wid + 1'b1;
        chk("lg_gnt", rd_gnt, 2'b01);
        chk("lg_ovr", overrun, 1);
        chk("lg_wid", win_id, exp_wid);
        chk("lg_sv", snap_valid, 1);
        cyc();
        rd_req = 2'b01;
        cyc();
        chk("lg_set_wins", rd_gnt, 2'b01);
        rd_req = 2'b00;
        cyc();
        for (int k = 3; k <= 8; k++) begin
            cnt_in = (k == 8) ? 32'h55 : k;
            sync_edge(); cyc();
            exp_wid = exp_wid + 1'b1;
            chk($sformatf("wr_wid_%0d", k), win_id, exp_wid);
            cyc(); cyc();
        end
        chk("wr_wrapped", win_id, 0);
        chk("pre_rst_en", cnt_en, 1);
        chk("pre_rst_snap", snap, 32'h55);

        // Asynchronous reset mid-COUNT
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        cyc();
        rst = 1'b0;
        sync_edge(); cyc();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_snap", snap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_gate_sequencer.md
PULSE_GATE_SEQUENCER -- requirements
Module: pulse_gate_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter CNT_W, default 32, setting the count width.
REQ-003 The block SHALL have parameter WID_W, default 16, setting the window-index width.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle arm request.
REQ-007 stop  input  1  one-cycle abort request.
REQ-008 cont  input  1  continuous mode, sampled with start.
REQ-009 win_len  input  8  gate length in sync periods, sampled with start.
REQ-010 sync_50Hz  input  1  50Hz sync level, already synchronous to clk.
REQ-011 cnt_in  input  CNT_W  running count from the pulse counter.
REQ-012 cnt_en  output  1  enable to the pulse counter.
REQ-013 cnt_clr  output  1  one-cycle clear pulse to the pulse counter.
REQ-014 snap  output  CNT_W  latched window count.
REQ-015 snap_valid  output  1  OR of the two reader pending flags.
REQ-016 rd_req  input  2  read requests: bit0 LCD, bit1 UART.
REQ-017 rd_gnt  output  2  one-hot, one-cycle read grants.
REQ-018 win_id  output  WID_W  count of completed windows.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 overrun  output  1  sticky unread-snapshot-overwritten flag.

Function
REQ-021 The FSM SHALL have states IDLE, ARM, COUNT, LATCH and CLEAR.
REQ-022 Sync edge detection SHALL register sync_50Hz once; an edge SHALL be defined as sync_50Hz=1 with the registered value=0.
REQ-023 In IDLE, start with stop=0 SHALL latch win_len (0 treated as 1) and cont, clear overrun and win_id, and go to ARM.
REQ-024 In ARM, cnt_en SHALL be 0; on a sync edge the block SHALL pulse cnt_clr for that cycle, zero the period counter and go to COUNT.
REQ-025 An edge present in the cycle start is accepted SHALL NOT be used.
REQ-026 In COUNT, cnt_en SHALL be 1 and each sync edge SHALL increment the period counter.
REQ-027 On the edge where the period count equals latched win_len-1, the block SHALL drop cnt_en in the next cycle and go to LATCH.
REQ-028 In LATCH (cnt_en=0), snap SHALL capture cnt_in, both pending flags SHALL set, and win_id SHALL increment, wrapping at 2^WID_W-1 to 0.
REQ-029 If either pending flag is already set at LATCH, overrun SHALL set and the snapshot SHALL be overwritten.
REQ-030 In CLEAR, cnt_clr SHALL pulse; the block SHALL then go to COUNT if cont=1 (dead time exactly 3 cycles, period counter zeroed) or to IDLE otherwise.
REQ-031 stop SHALL force IDLE on the next cycle from any state, with cnt_en=0 and no latch; snap, pending flags and win_id SHALL be retained.
REQ-032 stop SHALL win over a simultaneous start, and start SHALL be ignored when busy=1.
REQ-033 A reader request SHALL be eligible only while that reader's pending flag is set.
REQ-034 rd_gnt SHALL be registered, asserted one cycle after an eligible request, and SHALL clear that reader's flag.
REQ-035 At most one grant SHALL be issued per cycle.
REQ-036 When both readers are eligible, the arbiter SHALL grant round-robin, favouring the reader not granted last; the pointer resets to favour LCD.
REQ-037 A request held high after its grant SHALL receive no further grant until the next LATCH.
REQ-038 A LATCH coinciding with a grant SHALL leave the flag set (set wins) and SHALL set overrun.

Reset
REQ-039 On rst, the block SHALL asynchronously enter IDLE, with cnt_en, cnt_clr, snap, pending flags, rd_gnt, win_id, overrun, busy, latched win_len and the round-robin pointer all 0.
REQ-040 Reset mid-window SHALL discard the window without producing a snapshot.

Verification
REQ-041 Single-shot: start (win_len=3, cont=0), 4 edges, cnt_in=1234 at LATCH -> one cnt_clr at edge 1, cnt_en high for 3 periods, snap=1234, snap_valid=1, win_id=1, then IDLE.
REQ-042 Continuous with win_len=0: -> a window every sync period, 3-cycle cnt_en gap after each edge, win_id increments each period.
REQ-043 Both readers request in the same cycle after latch -> rd_gnt=01 then 10, snap_valid drops after the second grant; a held request gets no third grant.
REQ-044 LATCH with UART flag unread -> overrun=1, snap updated; the next start clears overrun.
REQ-045 stop in COUNT, and start+stop together in IDLE -> IDLE, cnt_en=0, win_id unchanged, no grant.
REQ-046 rst asserted mid-COUNT with snap=0x55 -> all outputs 0 immediately, without waiting for a clock edge.
